// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared SIMON32/64 constants, state enum and round/key helpers
package simon_pkg;

    localparam int WORD      = 16;
    localparam int ROUNDS    = 32;
    localparam int KEY_WORDS = 4;

    // z0 sequence, leftmost character stored in bit 61
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [15:0] C  = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DECRYPT
    } state_e;

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned s);
        return (v << s) | (v >> (WORD - s));
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] v, input int unsigned s);
        return (v >> s) | (v << (WORD - s));
    endfunction

    function automatic logic [15:0] f(input logic [15:0] v);
        return (rotl16(v, 1) & rotl16(v, 8)) ^ rotl16(v, 2);
    endfunction

    // ~k[j-4] ^ 3 folds into k[j-4] ^ C
    function automatic logic [15:0] key_step(input logic [15:0] km1,
                                             input logic [15:0] km3,
                                             input logic [15:0] km4,
                                             input logic [4:0]  idx);
        logic [15:0] t;
        t = rotr16(km1, 3) ^ km3;
        t = t ^ rotr16(t, 1);
        return C ^ km4 ^ t ^ {15'd0, Z0[6'd61 - {1'b0, idx}]};
    endfunction

endpackage

// File: rtl/simon_key_expander.sv
// rtl/simon_key_expander.sv - round-key buffer, expansion counter and schedule-valid flag
module simon_key_expander
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] key,
    input  logic        expand,
    input  logic [4:0]  rd_idx,
    output logic [15:0] rd_data,
    output logic        last,
    output logic        sched_valid
);

    logic [15:0] rk_q [ROUNDS];
    logic [15:0] rk_d [ROUNDS];
    logic [4:0]  j_q, j_d;
    logic        sched_valid_q, sched_valid_d;

    always_comb begin
        rk_d          = rk_q;
        j_d           = j_q;
        sched_valid_d = sched_valid_q;
        if (load) begin
            rk_d[0]       = key[15:0];
            rk_d[1]       = key[31:16];
            rk_d[2]       = key[47:32];
            rk_d[3]       = key[63:48];
            j_d           = 5'd4;
            sched_valid_d = 1'b0;
        end else if (expand) begin
            rk_d[j_q] = key_step(rk_q[j_q - 5'd1], rk_q[j_q - 5'd3],
                                 rk_q[j_q - 5'd4], j_q - 5'd4);
            j_d       = j_q + 5'd1;
            if (j_q == 5'd31) begin
                sched_valid_d = 1'b1;
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset on the array
    always_ff @(posedge clk) begin
        rk_q <= rk_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j_q           <= 5'd0;
            sched_valid_q <= 1'b0;
        end else begin
            j_q           <= j_d;
            sched_valid_q <= sched_valid_d;
        end
    end

    assign rd_data     = rk_q[rd_idx];
    assign last        = (j_q == 5'd31);
    assign sched_valid = sched_valid_q;

endmodule

// File: rtl/simon_decrypt_core.sv
// rtl/simon_decrypt_core.sv - iterative SIMON32/64 decryption with cached key schedule
module simon_decrypt_core
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        reuse_key,
    input  logic [31:0] ciphertext,
    input  logic [63:0] key,
    output logic        ready,
    output logic        pt_valid,
    output logic [31:0] plaintext
);

    state_e      state_q, state_d;
    logic [4:0]  r_q, r_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [31:0] pt_q, pt_d;
    logic        pt_valid_q, pt_valid_d;

    logic        ks_load, ks_expand, ks_last, sched_valid;
    logic [15:0] rk;
    logic [15:0] new_y;

    simon_key_expander u_key_expander (
        .clk         (clk),
        .rst         (rst),
        .load        (ks_load),
        .key         (key),
        .expand      (ks_expand),
        .rd_idx      (r_q),
        .rd_data     (rk),
        .last        (ks_last),
        .sched_valid (sched_valid)
    );

    assign new_y = x_q ^ f(y_q) ^ rk;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        x_d        = x_q;
        y_d        = y_q;
        pt_d       = pt_q;
        pt_valid_d = 1'b0;
        ks_load    = 1'b0;
        ks_expand  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d = ciphertext[31:16];
                    y_d = ciphertext[15:0];
                    if (reuse_key && sched_valid) begin
                        state_d = ST_DECRYPT;
                        r_d     = 5'd31;
                    end else begin
                        ks_load = 1'b1;
                        state_d = ST_EXPAND;
                    end
                end
            end
            ST_EXPAND: begin
                ks_expand = 1'b1;
                if (ks_last) begin
                    state_d = ST_DECRYPT;
                    r_d     = 5'd31;
                end
            end
            ST_DECRYPT: begin
                x_d = y_q;
                y_d = new_y;
                r_d = r_q - 5'd1;
                if (r_q == 5'd0) begin
                    pt_d       = {y_q, new_y};
                    pt_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            r_q        <= 5'd0;
            x_q        <= 16'd0;
            y_q        <= 16'd0;
            pt_q       <= 32'd0;
            pt_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pt_q       <= pt_d;
            pt_valid_q <= pt_valid_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign pt_valid  = pt_valid_q;
    assign plaintext = pt_q;

endmodule

// File: tb/tb_simon_decrypt_core.sv
// tb/tb_simon_decrypt_core.sv - scoreboard bench for simon_decrypt_core
module tb_simon_decrypt_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        reuse_key = 1'b0;
    logic [31:0] ciphertext = 32'd0;
    logic [63:0] key = 64'd0;
    logic        ready;
    logic        pt_valid;
    logic [31:0] plaintext;

    simon_decrypt_core dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reuse_key  (reuse_key),
        .ciphertext (ciphertext),
        .key        (key),
        .ready      (ready),
        .pt_valid   (pt_valid),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pt;
        int          acc;
        int          lat;
    } ent_t;

    localparam logic [63:0] STD_KEY = 64'h1918111009080100;
    localparam logic [31:0] STD_PT  = 32'h65656877;
    localparam logic [31:0] STD_CT  = 32'hc69be9bb;
    localparam logic [61:0] ZSEQ    = 62'b11111010001001010110000111001101111101000100101011000011100110;

    ent_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          pulses = 0;
    bit          sv_model = 1'b0;
    logic [63:0] cached_key = 64'd0;
    logic [31:0] pt_prev = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    function automatic logic [31:0] enc(input logic [63:0] k, input logic [31:0] p);
        logic [15:0] ks [32];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = ZSEQ;
        for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = ror(ks[i-1], 3) ^ ks[i-3];
            t = t ^ ror(t, 1);
            ks[i] = ~ks[i-4] ^ t ^ {15'd0, z[65-i]} ^ 16'h0003;
        end
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ ks[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Monitor: pop scoreboard on each result, check value, latency and hold
    always @(negedge clk) begin
        if (rst) begin
            pt_prev = 32'd0;
        end else begin
            if (pt_valid) begin
                pulses++;
                chk("pt_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("plaintext", plaintext, e.pt);
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("ready_at_pt", ready, 1'b1);
                end
            end else begin
                chk("pt_hold", plaintext, pt_prev);
            end
            pt_prev = plaintext;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        chk("ready_wait", ready, 1'b1);
    endtask

    // Drive one request at a negedge with ready high; returns 1ns after acceptance
    task automatic send(input logic [63:0] k, input logic [31:0] p, input bit reuse, input bit keep_start);
        ent_t e;
        bit   fast;
        fast  = reuse && sv_model;
        e.pt  = p;
        e.acc = cyc + 1;
        e.lat = fast ? 32 : 60;
        if (!fast) begin
            sv_model   = 1'b1;
            cached_key = k;
        end
        sb.push_back(e);
        key        = k;
        ciphertext = enc(fast ? cached_key : k, p);
        reuse_key  = reuse;
        start      = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_one(input logic [63:0] k, input logic [31:0] p, input bit reuse);
        wait_ready();
        send(k, p, reuse, 1'b0);
        drain();
    endtask

    task automatic reset_at(input int n);
        wait_ready();
        send(STD_KEY, STD_PT, 1'b0, 1'b0);
        repeat (n - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        sv_model = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_pt_valid", pt_valid, 1'b0);
        chk("rst_plaintext", plaintext, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [63:0] k;
        logic [31:0] p;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", ready, 1'b1);
        chk("reset_pt_valid", pt_valid, 1'b0);
        chk("reset_plaintext", plaintext, 32'd0);
        chk("model_vector", enc(STD_KEY, STD_PT), STD_CT);

        // standard vector: full then cached schedule
        run_one(STD_KEY, STD_PT, 1'b0);
        run_one(STD_KEY, STD_PT, 1'b1);

        // reuse request after reset falls back to full expansion
        @(posedge clk);
        #1;
        rst = 1'b1;
        sv_model = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_one(STD_KEY, STD_PT, 1'b1);

        // busy ignore: starts at E10 and E40 must be dropped
        p0 = pulses;
        wait_ready();
        send(STD_KEY, STD_PT, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        ciphertext = 32'hdeadbeef;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        start = 1'b1;
        ciphertext = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (70) @(negedge clk);
        chk("busy_one_pulse", 64'(pulses - p0), 64'd1);

        // reset mid-EXPAND and mid-DECRYPT, then recover
        reset_at(15);
        run_one(STD_KEY, STD_PT, 1'b0);
        reset_at(45);
        run_one(STD_KEY, STD_PT, 1'b1);

        // back-to-back with start held high
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wait_ready();
            send({$urandom, $urandom}, $urandom, 1'b0, i < 2);
        end
        drain();

        // round-trip sweep
        for (int i = 0; i < 1000; i++) begin
            p = $urandom;
            if ($urandom_range(0, 1) == 1 && sv_model) begin
                run_one(cached_key, p, 1'b1);
            end else begin
                k = {$urandom, $urandom};
                run_one(k, p, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simon_decrypt_core.md
# simon_decrypt_core

Iterative SIMON32/64 decryption core: accepts a 32-bit ciphertext block and 64-bit key over a ready/start handshake and returns the 32-bit plaintext. It is the inverse companion of the pipelined SIMON32/64 encryption core. Decryption consumes round keys last-first, so the block first expands the key schedule into a 32-entry round-key buffer, then runs 32 inverse rounds one per cycle. A cached schedule can be reused to skip expansion when the key is unchanged.

## Interface
- ROUNDS, 32: number of SIMON rounds; fixed for SIMON32/64. Not intended to be overridden.
- WORD, 16: word size n; fixed.
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only on a cycle where ready=1
- reuse_key  in  1  sampled with start; when 1 and the schedule is cached, key expansion is skipped
- ciphertext  in  32  [31:16]=x, [15:0]=y; sampled on acceptance
- key  in  64  k0=key[15:0], k1=[31:16], k2=[47:32], k3=[63:48]; sampled on acceptance
- ready  out  1  high in IDLE
- pt_valid  out  1  single-cycle pulse when plaintext is updated
- plaintext  out  32  result; holds until the next result or reset

## Operation
- f(v) = (rotl(v,1) & rotl(v,8)) ^ rotl(v,2).
- Inverse round r, state (x,y) → (y, x ^ f(y) ^ rk[r]).
- Key step j=4..31:
  - t = rotr(rk[j-1],3) ^ rk[j-3]
  - t ^= rotr(t,1)
  - rk[j] = ~rk[j-4] ^ t ^ Z0[j-4] ^ 16'h0003
  - Z0 is the 62-bit z0 sequence 1111101000100101011000011100110…, indexed from the left, bit 0 first.
- FSM states are IDLE, EXPAND and DECRYPT.
  - IDLE → start: latch ciphertext.
    - If reuse_key=1 and sched_valid=1: go to DECRYPT with r=31, keeping rk.
    - Otherwise: load rk[0..3] from key, clear sched_valid, go to EXPAND with j=4.
  - EXPAND: write rk[j] each cycle. After j=31, set sched_valid and go to DECRYPT with r=31.
  - DECRYPT: apply one inverse round per cycle using rk[r], decrementing r. The round with r=0 writes the result to plaintext, pulses pt_valid and returns to IDLE.
- All arithmetic is 16-bit with rotations modulo 16. There is no carry.
- start while ready=0 is ignored. It is not queued.
- reuse_key with sched_valid=0 performs a full expansion, with no error.
- Reset mid-operation:
  - Immediately enter IDLE.
  - Clear sched_valid, the counters and the state.
  - The rk buffer contents become don't-care.

## Timing
- Reset values: ready=1, pt_valid=0, plaintext=0, sched_valid=0, state=IDLE.
- Acceptance edge is E0 (start & ready). ready falls after E0.
- Full path:
  - E1..E28 write rk[4..31].
  - E29..E60 perform rounds 31..0.
  - pt_valid=1 and ready=1 in the cycle after E60.
  - Latency is 60 cycles from acceptance.
- Reuse path:
  - E1..E32 perform rounds 31..0.
  - Latency is 32 cycles.
- A start asserted in the pt_valid cycle is accepted, giving back-to-back throughput without a bubble.
- plaintext changes only on the final-round edge.

## Structure
- Package simon_pkg holds:
  - WORD, ROUNDS, KEY_WORDS=4
  - Z0 (62-bit constant) and C=16'hFFFC
  - FSM state enum
  - functions f(), rotl16/rotr16 and key_step()
- Shared with the encryption core, which switches to the package functions.
- One natural sub-module: simon_key_expander. It owns the rk buffer, the j counter and sched_valid, and exposes a read port rk[r] to the round datapath.

## Test plan
- Standard vector: key=64'h1918111009080100, ciphertext=32'hc69be9bb, reuse_key=0 → pt_valid 60 cycles after acceptance with plaintext=32'h65656877, then ready=1.
- Reuse path: repeat the vector with reuse_key=1 → same plaintext after 32 cycles. Then reset, and issue reuse_key=1 → 60-cycle full path.
- Busy ignore: start pulsed at E10 and E40 with a different ciphertext → the result is still 32'h65656877. Exactly one pt_valid.
- Reset mid-EXPAND (E15) and mid-DECRYPT (E45) → next cycle shows ready=1, pt_valid=0, plaintext=0. A following request decrypts correctly.
- Back-to-back: start held high continuously over 3 ciphertexts produced by the encryption core (random keys/plaintexts) → 3 pt_valid pulses 61 cycles apart, each matching the original plaintext.
- Round-trip sweep: 1000 random key/plaintext pairs, encrypt core → decrypt core, 50% reuse_key → every plaintext is recovered exactly.
